corelet_ws_ctrl: RTL and testbench
==================================

Name: corelet_ws_ctrl

Overview:
- Weight-stationary tile sequencer for the corelet datapath.
- On `start` it drives the corelet's 37-bit `inst` bus through five phases: fetch weights into L0, load the kernel into the MAC array, fetch activations, execute, and drain the OFIFO into psum SRAM.
- It also generates activation/weight SRAM (xmem) and psum SRAM (pmem) control, and sits between the top-level host interface and the corelet.

Parameters:
- row, 8, MAC array rows and L0 lanes
- col, 8, MAC array columns and OFIFO lanes
- addr_bw, 11, SRAM address width
- len_bw, 8, width of the activation vector count
- timeout, 255, drain-phase idle cycles before error abort

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous reset, active high
- start  in  1  single-cycle launch; ignored unless idle
- abort  in  1  synchronous abort, any state
- n_vec  in  len_bw  activation vectors per tile; latched at start
- w_base  in  addr_bw  xmem address of first weight vector; latched
- x_base  in  addr_bw  xmem address of first activation vector; latched
- p_base  in  addr_bw  pmem address for first output; latched
- relu_cfg  in  1  enable SFP ReLU during drain; latched
- acc_cfg  in  1  enable SFP accumulate during drain; latched
- ofifo_o_valid  in  1  from corelet; OFIFO holds a full row
- inst  out  37  corelet instruction bus
- xmem_cen  out  1  xmem chip enable, active low
- xmem_addr  out  addr_bw  xmem read address
- pmem_wen  out  1  pmem write enable, active high
- pmem_addr  out  addr_bw  pmem write address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- err  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset values: `inst`=0, `xmem_cen`=1, `xmem_addr`=0, `pmem_wen`=0, `pmem_addr`=0, `busy`=0, `done`=0, `err`=0, state=IDLE. All outputs are registered.
- `inst` fields: bit0 load, bit1 execute, bit2 l0_wr, bit3 l0_rd, bit6 ofifo_rd, bit33 acc, bit34 relu.
  - All other bits are held 0, including ififo bits [5:4], os_mode [35] and flush [36].
- xmem read latency is 1 cycle.
  - `inst[2]` is a registered copy of (`xmem_cen`==0), so each L0 write lands exactly one cycle after its read.
- IDLE: `start` with `n_vec`!=0 latches the config, clears `err` and goes to WFETCH. `start` with `n_vec`==0 pulses `done` without entering the phases.
- WFETCH: `col` cycles.
  - `xmem_cen`=0, `xmem_addr`=`w_base`+k for k=0..col-1.
  - Then 1 tail cycle (last `l0_wr`) before moving to KLOAD.
- KLOAD: `col` cycles with `inst[3]`=1 and `inst[0]`=1, then KGAP.
- KGAP: `row` idle cycles for weight settle, then XFETCH.
- XFETCH: `n_vec` reads at `x_base`+k, plus 1 tail cycle, then EXEC.
- EXEC: `n_vec` cycles with `inst[3]`=1 and `inst[1]`=1, then DRAIN.
- DRAIN: rd_cnt runs from 0 to `n_vec`-1.
  - In a cycle where `ofifo_o_valid`=1: `inst[6]`=1, `pmem_wen`=1, `pmem_addr`=`p_base`+rd_cnt, rd_cnt increments.
  - `inst[34:33]` = {`relu_cfg`, `acc_cfg`} for the whole DRAIN state.
  - After the `n_vec`-th read, go to DONE.
  - Idle counter resets on every read. Reaching `timeout` sets `err`=1 and goes to DONE.
- DONE: `done`=1 for one cycle, `busy`=0 on the next cycle, return to IDLE.
- Address arithmetic wraps modulo 2^addr_bw; no overflow flag.
- `abort` wins over all transitions: next cycle state=IDLE with all outputs at reset values except `err`, which is unchanged. No `done` pulse.
- `start` while busy: ignored, latched config unchanged.
- Asynchronous reset mid-tile: immediate return to reset values. The corelet must be reset alongside.

Decomposition:
- Shared package `corelet_pkg`:
  - state enum.
  - `inst` bit-index localparams: LOAD=0, EXEC=1, L0_WR=2, L0_RD=3, OFIFO_RD=6, ACC=33, RELU=34, OS=35, FLUSH=36.
  - `INST_W`=37.
- One sub-module, `phase_counter`: loadable down-counter with terminal-count flag, reused for the WFETCH, KLOAD, KGAP, XFETCH and EXEC lengths.

Test Plan:
- Basic tile: reset, then `start` with `n_vec`=4, `w_base`=0, `x_base`=16, `p_base`=100. Expected:
  - xmem addrs 0..7, then 16..19.
  - `inst[2]` high 8+4 cycles, each one cycle after its `cen`.
  - EXEC high exactly 4 cycles.
  - With `ofifo_o_valid` held 1: pmem writes 100..103, then one `done` pulse.
- Backpressure: `ofifo_o_valid` toggles 1,0,0,1,… -> `inst[6]` and `pmem_wen` are asserted only on valid cycles; `pmem_addr` stays contiguous; `done` follows the 4th read.
- Timeout: `ofifo_o_valid` stuck 0 in DRAIN -> `err`=1 after 255 idle cycles, then `done`; the next `start` clears `err`.
- Abort in EXEC on its 2nd cycle -> next cycle `inst`=0, `xmem_cen`=1, `busy`=0, no `done`. A fresh `start` then completes normally.
- Edge cases: `start` while busy -> ignored, latched `n_vec` unchanged. `n_vec`=0 -> `done` one cycle after `start`, no xmem activity. `x_base`=2046, `n_vec`=4 -> addrs 2046, 2047, 0, 1.
- Async reset asserted in WFETCH off a clock edge -> outputs reach reset values before the next rising edge.

Source files
------------

// File: rtl/corelet_pkg.sv
// rtl/corelet_pkg.sv - shared state encoding and corelet instruction bit map
package corelet_pkg;

  localparam int INST_W   = 37;
  localparam int LOAD     = 0;
  localparam int EXEC     = 1;
  localparam int L0_WR    = 2;
  localparam int L0_RD    = 3;
  localparam int OFIFO_RD = 6;
  localparam int ACC      = 33;
  localparam int RELU     = 34;
  localparam int OS       = 35;
  localparam int FLUSH    = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFETCH,
    S_KLOAD,
    S_KGAP,
    S_XFETCH,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter with terminal-count flag
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign tc = (count == '0);

endmodule

// File: rtl/corelet_ws_ctrl.sv
// rtl/corelet_ws_ctrl.sv - weight-stationary tile sequencer driving the corelet inst bus
module corelet_ws_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8,
  parameter int timeout = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [len_bw-1:0]  n_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               relu_cfg,
  input  logic               acc_cfg,
  input  logic               ofifo_o_valid,
  output logic [INST_W-1:0]  inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW0    = (len_bw > $clog2(col + 1)) ? len_bw : $clog2(col + 1);
  localparam int CNT_W  = (CW0 > $clog2(row)) ? CW0 : $clog2(row);
  localparam int IDLE_W = $clog2(timeout + 1);

  state_t             state;
  logic [len_bw-1:0]  n_vec_q;
  logic [addr_bw-1:0] x_base_q;
  logic [addr_bw-1:0] p_base_q;
  logic               relu_q;
  logic               acc_q;
  logic [len_bw-1:0]  rd_cnt;
  logic [IDLE_W-1:0]  idle_cnt;

  logic               cnt_load;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_val;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_tc;

  // Fetch phases load their length (not length-1): count 0 is the tail cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state)
      S_IDLE: begin
        cnt_load = start && !busy && (n_vec != '0);
        cnt_val  = CNT_W'(col);
      end
      S_WFETCH: begin
        cnt_load = cnt_tc;
        cnt_en   = !cnt_tc;
        cnt_val  = CNT_W'(col - 1);
      end
      S_KLOAD: begin
        cnt_load = cnt_tc;
        cnt_en   = !cnt_tc;
        cnt_val  = CNT_W'(row - 1);
      end
      S_KGAP: begin
        cnt_load = cnt_tc;
        cnt_en   = !cnt_tc;
        cnt_val  = CNT_W'(n_vec_q);
      end
      S_XFETCH: begin
        cnt_load = cnt_tc;
        cnt_en   = !cnt_tc;
        cnt_val  = CNT_W'(n_vec_q - len_bw'(1));
      end
      S_EXEC:  cnt_en = 1'b1;
      default: ;
    endcase
  end

  phase_counter #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_wen  <= 1'b0;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n_vec_q   <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      relu_q    <= 1'b0;
      acc_q     <= 1'b0;
      rd_cnt    <= '0;
      idle_cnt  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_wen  <= 1'b0;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inst[L0_WR]    <= !xmem_cen;
      inst[OFIFO_RD] <= 1'b0;
      pmem_wen       <= 1'b0;
      done           <= 1'b0;
      case (state)
        // busy is still high during the done pulse, so a start there is ignored
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            if (n_vec == '0) begin
              done <= 1'b1;
            end else begin
              n_vec_q   <= n_vec;
              x_base_q  <= x_base;
              p_base_q  <= p_base;
              relu_q    <= relu_cfg;
              acc_q     <= acc_cfg;
              err       <= 1'b0;
              busy      <= 1'b1;
              xmem_cen  <= 1'b0;
              xmem_addr <= w_base;
              state     <= S_WFETCH;
            end
          end
        end
        S_WFETCH, S_XFETCH: begin
          if (cnt_tc) begin
            inst[L0_RD] <= 1'b1;
            if (state == S_WFETCH) begin
              inst[LOAD] <= 1'b1;
              state      <= S_KLOAD;
            end else begin
              inst[EXEC] <= 1'b1;
              state      <= S_EXEC;
            end
          end else if (cnt == CNT_W'(1)) begin
            xmem_cen <= 1'b1;
          end else begin
            xmem_addr <= xmem_addr + addr_bw'(1);
          end
        end
        S_KLOAD: begin
          if (cnt_tc) begin
            inst[LOAD]  <= 1'b0;
            inst[L0_RD] <= 1'b0;
            state       <= S_KGAP;
          end
        end
        S_KGAP: begin
          if (cnt_tc) begin
            xmem_cen  <= 1'b0;
            xmem_addr <= x_base_q;
            state     <= S_XFETCH;
          end
        end
        S_EXEC: begin
          if (cnt_tc) begin
            inst[EXEC]  <= 1'b0;
            inst[L0_RD] <= 1'b0;
            inst[RELU]  <= relu_q;
            inst[ACC]   <= acc_q;
            rd_cnt      <= '0;
            idle_cnt    <= '0;
            state       <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ofifo_o_valid) begin
            inst[OFIFO_RD] <= 1'b1;
            pmem_wen       <= 1'b1;
            pmem_addr      <= p_base_q + addr_bw'(rd_cnt);
            rd_cnt         <= rd_cnt + len_bw'(1);
            idle_cnt       <= '0;
            if (rd_cnt == n_vec_q - len_bw'(1))
              state <= S_DONE;
          end else if (idle_cnt == IDLE_W'(timeout - 1)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          inst  <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ws_ctrl.sv
// tb/tb_corelet_ws_ctrl.sv - self-checking bench for corelet_ws_ctrl
module tb_corelet_ws_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int LW  = 8;
  localparam int TMO = 255;
  localparam int AMOD = 1 << AW;
  localparam logic [36:0] ALLOWED = 37'h60000004F;

  logic          clk = 1'b0;
  logic          reset, start, abort, relu_cfg, acc_cfg, ofifo_o_valid;
  logic [LW-1:0] n_vec;
  logic [AW-1:0] w_base, x_base, p_base;
  logic [36:0]   inst;
  logic          xmem_cen, pmem_wen, busy, done, err;
  logic [AW-1:0] xmem_addr, pmem_addr;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int xq[$];
  int pq[$];
  int l0_n, l0_bad, exec_n, load_n, wr_bad, bad_bits, cfg_bad, done_n;
  int done_cyc, last_wr_cyc, last_exec_cyc, err_cyc;
  bit prev_rd;
  int vmode, vidx;
  logic [1:0] exp_cfg;

  corelet_ws_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW), .timeout(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .n_vec         (n_vec),
    .w_base        (w_base),
    .x_base        (x_base),
    .p_base        (p_base),
    .relu_cfg      (relu_cfg),
    .acc_cfg       (acc_cfg),
    .ofifo_o_valid (ofifo_o_valid),
    .inst          (inst),
    .xmem_cen      (xmem_cen),
    .xmem_addr     (xmem_addr),
    .pmem_wen      (pmem_wen),
    .pmem_addr     (pmem_addr),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    xq.delete();
    pq.delete();
    l0_n = 0; l0_bad = 0; exec_n = 0; load_n = 0;
    wr_bad = 0; bad_bits = 0; cfg_bad = 0; done_n = 0;
    done_cyc = -1; last_wr_cyc = -1; last_exec_cyc = -1; err_cyc = -1;
    prev_rd = 1'b0;
    vidx = 0;
  endtask

  // One clock: sample outputs on the falling edge, then drive ofifo_o_valid.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!xmem_cen) xq.push_back(int'(xmem_addr));
    if (inst[2]) l0_n++;
    if (inst[2] !== prev_rd) l0_bad++;
    prev_rd = !xmem_cen;
    if (inst[1]) begin exec_n++; last_exec_cyc = cyc; end
    if (inst[0]) load_n++;
    if (pmem_wen) begin pq.push_back(int'(pmem_addr)); last_wr_cyc = cyc; end
    if (inst[6] !== pmem_wen) wr_bad++;
    if (inst[6] && inst[34:33] !== exp_cfg) cfg_bad++;
    if ((inst & ~ALLOWED) != '0) bad_bits++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (err && err_cyc < 0) err_cyc = cyc;
    case (vmode)
      0: ofifo_o_valid = 1'b1;
      1: ofifo_o_valid = (vidx % 3 == 0);
      2: ofifo_o_valid = 1'b0;
      default: ofifo_o_valid = 1'($urandom_range(0, 1));
    endcase
    vidx++;
  endtask

  task automatic run_tile(input string name, input int nv, input int wb, input int xb,
                          input int pb, input bit r, input bit a, input int mode,
                          input bit exp_err);
    int exp_x[$];
    int mism;
    int guard;
    clear_mon();
    vmode = mode;
    exp_cfg = {r, a};
    n_vec = LW'(nv); w_base = AW'(wb); x_base = AW'(xb); p_base = AW'(pb);
    relu_cfg = r; acc_cfg = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_after_start"}, int'(busy), 1);
    chk({name, "_err_cleared"}, int'(err), 0);
    repeat (4) tick();
    n_vec = LW'(nv + 3); w_base = AW'(wb + 5); x_base = AW'(xb + 7); p_base = AW'(pb + 9);
    relu_cfg = !r; acc_cfg = !a;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (done_n == 0 && guard < 800) begin
      tick();
      guard++;
    end
    chk({name, "_done_seen"}, done_n, 1);
    tick();
    tick();
    chk({name, "_busy_low_after_done"}, int'(busy), 0);
    chk({name, "_single_done"}, done_n, 1);

    for (int k = 0; k < COL; k++) exp_x.push_back((wb + k) % AMOD);
    for (int k = 0; k < nv; k++) exp_x.push_back((xb + k) % AMOD);
    chk({name, "_xmem_reads"}, xq.size(), exp_x.size());
    mism = 0;
    for (int i = 0; i < xq.size() && i < exp_x.size(); i++)
      if (xq[i] != exp_x[i]) mism++;
    chk({name, "_xmem_addr_mism"}, mism, 0);
    chk({name, "_l0_wr_cycles"}, l0_n, COL + nv);
    chk({name, "_l0_wr_lag"}, l0_bad, 0);
    chk({name, "_load_cycles"}, load_n, COL);
    chk({name, "_exec_cycles"}, exec_n, nv);
    chk({name, "_ofifo_rd_eq_wen"}, wr_bad, 0);
    chk({name, "_stray_inst_bits"}, bad_bits, 0);
    chk({name, "_drain_cfg"}, cfg_bad, 0);
    chk({name, "_err"}, int'(err), int'(exp_err));
    if (!exp_err) begin
      chk({name, "_pmem_writes"}, pq.size(), nv);
      mism = 0;
      for (int i = 0; i < pq.size() && i < nv; i++)
        if (pq[i] != (pb + i) % AMOD) mism++;
      chk({name, "_pmem_addr_mism"}, mism, 0);
      chk({name, "_done_after_last_wr"}, done_cyc - last_wr_cyc, 1);
    end else begin
      chk({name, "_pmem_writes"}, pq.size(), 0);
      chk({name, "_timeout_len"}, err_cyc - last_exec_cyc, TMO + 1);
      chk({name, "_done_after_err"}, done_cyc - err_cyc, 1);
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; abort = 1'b0; relu_cfg = 1'b0; acc_cfg = 1'b0;
    ofifo_o_valid = 1'b0; n_vec = '0; w_base = '0; x_base = '0; p_base = '0;
    vmode = 2; exp_cfg = 2'b00;
    clear_mon();
    tick();
    tick();
    chk("rst_inst", int'(inst == '0), 1);
    chk("rst_cen", int'(xmem_cen), 1);
    chk("rst_xaddr", int'(xmem_addr), 0);
    chk("rst_wen", int'(pmem_wen), 0);
    chk("rst_paddr", int'(pmem_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0;
    tick();

    run_tile("basic", 4, 0, 16, 100, 1'b0, 1'b0, 0, 1'b0);
    run_tile("bp", 4, 40, 200, 300, 1'b1, 1'b0, 1, 1'b0);
    run_tile("tmo", 3, 8, 24, 500, 1'b0, 1'b1, 2, 1'b1);
    run_tile("after_tmo", 2, 1, 2, 3, 1'b1, 1'b1, 0, 1'b0);

    // abort on the second EXEC cycle
    clear_mon();
    vmode = 0;
    n_vec = LW'(4); w_base = '0; x_base = AW'(16); p_base = AW'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (exec_n < 2 && guard < 200) begin
      tick();
      guard++;
    end
    chk("abort_reach_exec2", exec_n, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_inst", int'(inst == '0), 1);
    chk("abort_cen", int'(xmem_cen), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (20) tick();
    chk("abort_no_done", done_n, 0);
    run_tile("post_abort", 4, 0, 16, 100, 1'b0, 1'b1, 0, 1'b0);

    // zero-length tile
    clear_mon();
    n_vec = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nv0_done", int'(done), 1);
    chk("nv0_busy", int'(busy), 0);
    tick();
    chk("nv0_done_pulse", int'(done), 0);
    repeat (3) tick();
    chk("nv0_no_xmem", xq.size(), 0);
    chk("nv0_done_count", done_n, 1);

    run_tile("wrap", 4, 2044, 2046, 2046, 1'b1, 1'b1, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      int m;
      m = int'($urandom_range(0, 2));
      run_tile("rnd", int'($urandom_range(1, 12)), int'($urandom_range(0, AMOD - 1)),
               int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (m == 2) ? 3 : m, 1'b0);
    end

    // asynchronous reset in WFETCH, between clock edges
    clear_mon();
    vmode = 0;
    n_vec = LW'(4); w_base = AW'(32); x_base = AW'(64); p_base = AW'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("areset_in_wfetch", int'(xmem_cen), 0);
    #2 reset = 1'b1;
    #1;
    chk("areset_inst", int'(inst == '0), 1);
    chk("areset_cen", int'(xmem_cen), 1);
    chk("areset_xaddr", int'(xmem_addr), 0);
    chk("areset_busy", int'(busy), 0);
    tick();
    reset = 1'b0;
    tick();
    run_tile("post_reset", 5, 10, 20, 30, 1'b0, 1'b0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
